// File: rtl/code_checker_if.sv
// Load/compare bus between the lock controller (master) and the code checker (slave).
interface code_checker_if #(
    parameter int DIGIT_W = 4,
    parameter int LEN_W   = 4
);
    logic               reset_signal;
    logic               ld_pass;
    logic               ld_input;
    logic [DIGIT_W-1:0] digit_in;
    logic               digit_valid;
    logic               compare_signal;
    logic               done_compare;
    logic               match;
    logic [LEN_W-1:0]   pass_len;
    logic [LEN_W-1:0]   input_len;
    logic               overflow;
    logic               busy;

    modport master (
        output reset_signal, ld_pass, ld_input, digit_in, digit_valid, compare_signal,
        input  done_compare, match, pass_len, input_len, overflow, busy
    );

    modport slave (
        input  reset_signal, ld_pass, ld_input, digit_in, digit_valid, compare_signal,
        output done_compare, match, pass_len, input_len, overflow, busy
    );
endinterface

// File: rtl/code_checker.sv
// Stores password and entry digit sequences and compares them digit by digit on request.
// Build macro CODE_CHECKER_EARLY_EXIT_EN: end the compare right after the first mismatching digit.
module code_checker #(
    parameter int DIGIT_W = 4,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic          clk,
    input  logic          system_reset,
    code_checker_if.slave bus
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
    localparam logic [LEN_W-1:0] ZERO_L    = LEN_W'(0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIGIT_W-1:0] r_pass  [DEPTH];
    logic [DIGIT_W-1:0] r_entry [DEPTH];
    logic [LEN_W-1:0]   r_pass_len;
    logic [LEN_W-1:0]   r_input_len;
    logic [LEN_W-1:0]   r_idx;
    logic               r_ld_pass_d;
    logic               r_acc;
    logic               r_done;
    logic               r_match;
    logic               r_overflow;
    logic               r_busy;

    logic [LEN_W-1:0]   w_pass_len_nxt;
    logic [LEN_W-1:0]   w_input_len_nxt;
    logic [LEN_W-1:0]   w_idx_nxt;
    logic [LEN_W-1:0]   w_pass_base;
    logic               w_acc_nxt;
    logic               w_done_nxt;
    logic               w_match_nxt;
    logic               w_overflow_nxt;
    logic               w_busy_nxt;
    logic               w_pass_we;
    logic               w_entry_we;
    logic               w_stop;
    logic [IDX_W-1:0]   w_pass_waddr;
    logic [IDX_W-1:0]   w_entry_waddr;
    logic               w_ld_pass_rise;
    logic               w_lens_ok;
    logic               w_digit_eq;
    logic               w_last;

    assign w_ld_pass_rise = bus.ld_pass & ~r_ld_pass_d;
    assign w_lens_ok      = (r_pass_len == r_input_len) && (r_pass_len != ZERO_L);
    assign w_digit_eq     = (r_pass[r_idx[IDX_W-1:0]] == r_entry[r_idx[IDX_W-1:0]]);
    // Unequal or empty lengths take a single compare cycle with a forced-zero verdict.
    assign w_last         = ~w_lens_ok || (r_idx == (r_pass_len - ONE_L));
    assign w_pass_waddr   = w_pass_base[IDX_W-1:0];
    assign w_entry_waddr  = r_input_len[IDX_W-1:0];

    assign bus.done_compare = r_done;
    assign bus.match        = r_match;
    assign bus.pass_len     = r_pass_len;
    assign bus.input_len    = r_input_len;
    assign bus.overflow     = r_overflow;
    assign bus.busy         = r_busy;

    always_comb begin
        w_state_nxt     = r_state;
        w_pass_len_nxt  = r_pass_len;
        w_input_len_nxt = r_input_len;
        w_idx_nxt       = r_idx;
        w_acc_nxt       = r_acc;
        w_done_nxt      = r_done;
        w_match_nxt     = r_match;
        w_overflow_nxt  = r_overflow;
        w_busy_nxt      = r_busy;
        w_pass_we       = 1'b0;
        w_entry_we      = 1'b0;
        w_pass_base     = r_pass_len;
        w_stop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.compare_signal) begin
                    w_state_nxt = S_COMPARE;
                    w_idx_nxt   = ZERO_L;
                    w_acc_nxt   = w_lens_ok;
                    w_match_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end else begin
                    if (w_ld_pass_rise) begin
                        w_pass_base    = ZERO_L;
                        w_overflow_nxt = 1'b0;
                    end else begin
                        w_pass_base    = r_pass_len;
                    end
                    w_pass_len_nxt = w_pass_base;
                    if (bus.ld_pass && bus.digit_valid) begin
                        if (w_pass_base == MAX_LEN_L) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_pass_we      = 1'b1;
                            w_pass_len_nxt = w_pass_base + ONE_L;
                        end
                    end else if (bus.ld_input && bus.digit_valid && bus.reset_signal) begin
                        if (r_input_len == MAX_LEN_L) begin
                            w_overflow_nxt  = 1'b1;
                        end else begin
                            w_entry_we      = 1'b1;
                            w_input_len_nxt = r_input_len + ONE_L;
                        end
                    end else begin
                        w_pass_we  = 1'b0;
                        w_entry_we = 1'b0;
                    end
                    if (!bus.reset_signal) begin
                        w_input_len_nxt = ZERO_L;
                        w_done_nxt      = 1'b0;
                    end else begin
                        w_done_nxt      = r_done;
                    end
                end
            end
            S_COMPARE: begin
                w_acc_nxt = r_acc & w_digit_eq;
`ifdef CODE_CHECKER_EARLY_EXIT_EN
                w_stop = w_last || !w_digit_eq;
`else
                w_stop = w_last;
`endif
                if (w_stop) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_idx_nxt   = r_idx + ONE_L;
                end
            end
            S_DONE: begin
                if (!bus.compare_signal) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b0;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_match_nxt = r_acc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            r_state     <= S_IDLE;
            r_pass_len  <= ZERO_L;
            r_input_len <= ZERO_L;
            r_idx       <= ZERO_L;
            r_ld_pass_d <= 1'b0;
            r_acc       <= 1'b0;
            r_done      <= 1'b0;
            r_match     <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pass[i]  <= '0;
                r_entry[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_pass_len  <= w_pass_len_nxt;
            r_input_len <= w_input_len_nxt;
            r_idx       <= w_idx_nxt;
            r_ld_pass_d <= bus.ld_pass;
            r_acc       <= w_acc_nxt;
            r_done      <= w_done_nxt;
            r_match     <= w_match_nxt;
            r_overflow  <= w_overflow_nxt;
            r_busy      <= w_busy_nxt;
            if (w_pass_we) begin
                r_pass[w_pass_waddr] <= bus.digit_in;
            end
            if (w_entry_we) begin
                r_entry[w_entry_waddr] <= bus.digit_in;
            end
        end
    end
endmodule
